stepper_seq: RTL and testbench

STEPPER_SEQ -- requirements
Module: stepper_seq

---
 rtl/stepper_seq.sv | 118 +++++++++++
 tb/tb_stepper_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/stepper_seq.sv
// Stepper motion sequencer: accepts move commands and paces phase steps for a downstream driver.
// After a move the coils stay energised for a hold time, then the block releases them.
module stepper_seq #(
  parameter int MIN_PERIOD  = 16,
  parameter int HOLD_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_dir,
  input  logic [15:0] cmd_steps,
  input  logic [15:0] cmd_period,
  input  logic        abort,
  output logic        enable,
  output logic        dir,
  output logic [2:0]  cnt8,
  output logic        busy,
  output logic        done,
  output logic [15:0] steps_left
);

  localparam int HW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
  // Zero and one hold cycles both mean leaving HOLD on the first count.
  localparam logic [HW-1:0] HOLD_LAST = (HOLD_CYCLES == 0) ? '0 : HW'(HOLD_CYCLES - 1);
  localparam logic [15:0]   MIN_P     = 16'(MIN_PERIOD);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t        state;
  logic [15:0]   period_m1;
  logic [15:0]   pcnt;
  logic [HW-1:0] hcnt;
  logic [15:0]   eff_period;
  logic [15:0]   eff_m1;
  logic          handshake;
  logic          step_term;

  assign cmd_ready = (state != RUN) && !abort && rst_n;

  always_comb begin
    eff_period = (cmd_period < MIN_P) ? MIN_P : cmd_period;
    eff_m1     = (eff_period == 16'd0) ? 16'd0 : eff_period - 16'd1;
    handshake  = cmd_valid && cmd_ready;
    step_term  = (pcnt == period_m1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      enable     <= 1'b0;
      dir        <= 1'b0;
      cnt8       <= 3'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      steps_left <= 16'd0;
      period_m1  <= 16'd0;
      pcnt       <= 16'd0;
      hcnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          // Abort wins over a coinciding terminal count, so no step is taken.
          if (abort) begin
            state <= HOLD;
            busy  <= 1'b0;
            done  <= 1'b1;
            hcnt  <= '0;
          end else if (step_term) begin
            cnt8       <= cnt8 + 3'd1;
            steps_left <= steps_left - 16'd1;
            pcnt       <= 16'd0;
            if (steps_left == 16'd1) begin
              state <= HOLD;
              busy  <= 1'b0;
              done  <= 1'b1;
              hcnt  <= '0;
            end
          end else begin
            pcnt <= pcnt + 16'd1;
          end
        end
        default: begin
          if (handshake) begin
            dir        <= cmd_dir;
            steps_left <= cmd_steps;
            period_m1  <= eff_m1;
            pcnt       <= 16'd0;
            hcnt       <= '0;
            enable     <= 1'b1;
            if (cmd_steps == 16'd0) begin
              state <= HOLD;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end else if (abort) begin
            state  <= IDLE;
            enable <= 1'b0;
            hcnt   <= '0;
          end else if (state == HOLD) begin
            if (hcnt == HOLD_LAST) begin
              state  <= IDLE;
              enable <= 1'b0;
              hcnt   <= '0;
            end else begin
              hcnt <= hcnt + HW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stepper_seq.sv
// Randomised bench for stepper_seq against a time-based move model.
// The model derives step counts from elapsed cycles since the handshake rather than a period counter.
module tb_stepper_seq;

  localparam int MIN_P  = 4;
  localparam int HOLD_C = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [15:0] cmd_steps;
  logic [15:0] cmd_period;
  logic        abort;
  logic        enable;
  logic        dir;
  logic [2:0]  cnt8;
  logic        busy;
  logic        done;
  logic [15:0] steps_left;

  always #5 clk = ~clk;

  stepper_seq #(.MIN_PERIOD(MIN_P), .HOLD_CYCLES(HOLD_C)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir),
    .cmd_steps(cmd_steps),
    .cmd_period(cmd_period),
    .abort(abort),
    .enable(enable),
    .dir(dir),
    .cnt8(cnt8),
    .busy(busy),
    .done(done),
    .steps_left(steps_left)
  );

  int total = 0;
  int bad   = 0;

  // Model: a move is described by its start cycle, length and period.
  int cyc = 0;
  bit m_run = 0, m_hold = 0, m_dir = 0, m_done = 0;
  int run_t0 = 0, run_n = 0, run_p = 1, run_base = 0, hold_t0 = 0;
  int m_cnt = 0, m_left = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic enterHold();
    m_run  = 0;
    m_hold = 1;
    hold_t0 = cyc;
    m_done = 1;
  endtask

  task automatic modelEdge(input bit v, input bit d, input int s, input int p,
                           input bit ab, input bit r);
    bit rdy;
    int el, due;
    rdy = !m_run && !ab && r;
    cyc++;
    m_done = 0;
    if (!r) begin
      m_run = 0; m_hold = 0; m_cnt = 0; m_left = 0; m_dir = 0;
    end else if (m_run) begin
      el = cyc - run_t0;
      // Abort freezes progress at the steps completed before this edge.
      due = ab ? (el - 1) / run_p : el / run_p;
      m_left = run_n - due;
      m_cnt  = run_base + due;
      if (ab || due == run_n) enterHold();
    end else if (v && rdy) begin
      m_dir = d; m_left = s; run_n = s;
      run_p = (p < MIN_P) ? MIN_P : p;
      run_t0 = cyc; run_base = m_cnt;
      if (s == 0) enterHold();
      else begin m_run = 1; m_hold = 0; end
    end else if (ab) begin
      m_hold = 0;
    end else if (m_hold && (cyc - hold_t0) >= ((HOLD_C < 1) ? 1 : HOLD_C)) begin
      m_hold = 0;
    end
  endtask

  task automatic applyStimulus(input bit v, input bit d, input int s, input int p,
                               input bit ab, input bit r);
    cmd_valid  = v;
    cmd_dir    = d;
    cmd_steps  = 16'(s);
    cmd_period = 16'(p);
    abort      = ab;
    rst_n      = r;
    #1;
    checkOutput("cmd_ready", {31'd0, cmd_ready}, {31'd0, !m_run && !ab && r});
    @(posedge clk);
    modelEdge(v, d, s, p, ab, r);
    #1;
    checkOutput("enable", {31'd0, enable}, {31'd0, m_run || m_hold});
    checkOutput("busy", {31'd0, busy}, {31'd0, m_run});
    checkOutput("done", {31'd0, done}, {31'd0, m_done});
    checkOutput("dir", {31'd0, dir}, {31'd0, m_dir});
    checkOutput("cnt8", {29'd0, cnt8}, m_cnt % 8);
    checkOutput("steps_left", {16'd0, steps_left}, m_left);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    bit v, d, ab, r;
    int s, p, sel;
    $display("[TB] start");
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    // Basic move, accepted on the first cycle out of reset.
    applyStimulus(1, 1, 3, 5, 0, 1);
    idleCycles(30);
    // Period clamp and cnt8 wrap.
    applyStimulus(1, 0, 10, 1, 0, 1);
    idleCycles(50);
    // Abort coinciding with the third terminal count, then a new move during HOLD.
    applyStimulus(1, 1, 100, 8, 0, 1);
    idleCycles(23);
    applyStimulus(0, 0, 0, 0, 1, 1);
    idleCycles(3);
    applyStimulus(1, 0, 2, 4, 0, 1);
    idleCycles(30);
    // Zero-step command, then valid with abort in IDLE.
    applyStimulus(1, 1, 0, 5, 0, 1);
    idleCycles(15);
    applyStimulus(1, 1, 5, 5, 1, 1);
    idleCycles(3);
    // Reset in the middle of a move, then an immediate new command.
    applyStimulus(1, 1, 20, 4, 0, 1);
    idleCycles(6);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 3, 4, 0, 1);
    idleCycles(25);
    for (int i = 0; i < 5000; i++) begin
      v   = ($urandom_range(0, 99) < 25);
      d   = 1'($urandom);
      sel = $urandom_range(0, 19);
      s   = (sel == 0) ? 0 : (sel == 1) ? 65535 : $urandom_range(1, 12);
      p   = ($urandom_range(0, 49) == 0) ? 65535 : $urandom_range(0, 12);
      ab  = ($urandom_range(0, 99) < 3);
      r   = ($urandom_range(0, 199) != 0);
      applyStimulus(v, d, s, p, ab, r);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
